jt12_timer_regs: RTL

CPU-side register front end for the timer block. Decodes bus writes to the part-I address/data ports, holds timer registers 0x24–0x27, and drives the timer inputs: value_A, value_B, load_A/B, clr_flag_A/B, enable_irq_A/B. Generates the busy flag after each data write and returns the status byte built from the timer flags. Sits directly upstream of jt12_timers; its flag_A/flag_B inputs come back from that block.

---
 rtl/jt12_timer_regs.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jt12_timer_regs.sv
// CPU-side register front end for the jt12 timers: decodes part-I address/data
// writes, holds timer registers 0x24-0x27, runs the busy counter and the status byte.
module jt12_timer_regs #(
  parameter int unsigned BUSY_CYCLES = 32  // clk_en cycles of busy per data write, 1..63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] dout,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);

  localparam logic [7:0] REG_TA_HI = 8'h24;
  localparam logic [7:0] REG_TA_LO = 8'h25;
  localparam logic [7:0] REG_TB    = 8'h26;
  localparam logic [7:0] REG_CTRL  = 8'h27;

  logic             wr_act;
  logic             wr_act_l;
  logic             wr_evt;
  logic             addr_wr;
  logic             data_wr;
  logic             reg_wr;
  logic [7:0]       sel;
  logic             sel_ok;
  logic [CNT_W-1:0] busy_cnt;
  logic             busy;

  // A strobe held over several clocks must count as one write, so only the
  // rising edge of the combined strobe produces an event.
  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_evt  = wr_act & ~wr_act_l;
  assign addr_wr = wr_evt & ~addr[0];
  assign data_wr = wr_evt &  addr[0];
  assign reg_wr  = data_wr & ~addr[1] & sel_ok;
  assign busy    = (busy_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_l <= 1'b0;
    end else begin
      wr_act_l <= wr_act;
    end
  end

  // Part-II addresses are decoded elsewhere; selecting one disarms this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= 8'h00;
      sel_ok <= 1'b0;
    end else if (addr_wr) begin
      if (!addr[1]) begin
        sel    <= din;
        sel_ok <= 1'b1;
      end else begin
        sel_ok <= 1'b0;
      end
    end
  end

  // NOTE: only a handful of flops here, so every one is reset; this keeps
  // the timer inputs inert until the CPU programs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      ch3_mode     <= 2'b00;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (reg_wr) begin
        case (sel)
          REG_TA_HI: value_A[9:2] <= din;
          REG_TA_LO: value_A[1:0] <= din[1:0];
          REG_TB:    value_B      <= din;
          REG_CTRL: begin
            load_A       <= din[0];
            load_B       <= din[1];
            enable_irq_A <= din[2];
            enable_irq_B <= din[3];
            clr_flag_A   <= din[4];
            clr_flag_B   <= din[5];
            ch3_mode     <= din[7:6];
          end
          default: ;
        endcase
      end
    end
  end

  // Any data write restarts busy, even one that changes no register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (data_wr) begin
      busy_cnt <= BUSY_LOAD;
    end else if (clk_en && busy) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else begin
      dout <= {busy, 5'b00000, flag_B, flag_A};
    end
  end

endmodule
